// File: rtl/fifo_sync_thresh_pkg.sv
// Shared types, reset values and sizing helper for the thresholded synchronous FIFO.
package fifo_sync_thresh_pkg;

  function automatic int unsigned calc_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/fifo_sync_thresh_if.sv
// Producer/consumer bundle for fifo_sync_thresh (intf_FIFO-style signal names).
interface fifo_sync_thresh_if
  import fifo_sync_thresh_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned CNT_W = calc_addr_w(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data_in;
  logic                  Wr_enable;
  logic                  Read_enable;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data_in, Wr_enable, Read_enable, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, Wr_enable, Read_enable, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_thresh_mem.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read, no reset.
module fifo_mem
  import fifo_sync_thresh_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [calc_addr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [calc_addr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]          rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_thresh.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_sync_thresh
  import fifo_sync_thresh_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = 12,
  parameter int unsigned AE_THRESH  = 4
) (
  input logic             clk,
  input logic             reset,
  fifo_sync_thresh_if.slave bus
);
  localparam int unsigned ADDR_W = calc_addr_w(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q, count_d;
  fifo_status_t          st_q, st_d;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] head;

  // A write while full still goes in when a read frees the head slot this cycle.
  assign rd_ok = bus.Read_enable & ~st_q.empty;
  assign wr_ok = bus.Wr_enable & (~st_q.full | bus.Read_enable);

  always_comb begin
    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are registered from the next count; a new error beats a simultaneous clear.
  always_comb begin
    st_d              = st_q;
    st_d.full         = (count_d == CNT_W'(DEPTH));
    st_d.empty        = (count_d == '0);
    st_d.almost_full  = (count_d >= CNT_W'(AF_THRESH));
    st_d.almost_empty = (count_d <= CNT_W'(AE_THRESH));
    if (bus.Wr_enable & st_q.full & ~bus.Read_enable) st_d.overflow = 1'b1;
    else if (bus.clr_err)                             st_d.overflow = 1'b0;
    if (bus.Read_enable & st_q.empty)                 st_d.underflow = 1'b1;
    else if (bus.clr_err)                             st_d.underflow = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      st_q    <= STATUS_RST;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      count_q <= count_d;
      st_q    <= st_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

`ifdef FIFO_FWFT_EN
  // Head is visible as soon as empty drops, which is the cycle after the write edge.
  always_comb begin
    bus.data_out = '0;
    if (!st_q.empty) bus.data_out = head;
  end
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     dout_q <= '0;
    else if (rd_ok) dout_q <= head;
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = st_q.full;
  assign bus.empty        = st_q.empty;
  assign bus.almost_full  = st_q.almost_full;
  assign bus.almost_empty = st_q.almost_empty;
  assign bus.overflow     = st_q.overflow;
  assign bus.underflow    = st_q.underflow;
endmodule

// File: tb/tb_fifo_sync_thresh.sv
// Directed scoreboard bench for fifo_sync_thresh (DATA_WIDTH=32, DEPTH=16, AF=12, AE=4).
module tb_fifo_sync_thresh;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_sync_thresh_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_sync_thresh #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (12),
    .AE_THRESH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mq [$];
  logic [DW-1:0] exp_q [$];
  int unsigned   mcount = 0;
  logic          mov = 1'b0;
  logic          mun = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags();
    check("count",        DW'(bus.count),        DW'(mcount));
    check("full",         DW'(bus.full),         DW'(mcount == DEPTH));
    check("empty",        DW'(bus.empty),        DW'(mcount == 0));
    check("almost_full",  DW'(bus.almost_full),  DW'(mcount >= 12));
    check("almost_empty", DW'(bus.almost_empty), DW'(mcount <= 4));
    check("overflow",     DW'(bus.overflow),     DW'(mov));
    check("underflow",    DW'(bus.underflow),    DW'(mun));
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    mcount = 0;
    mov    = 1'b0;
    mun    = 1'b0;
  endtask

  // One clock cycle of stimulus; model updated from pre-edge state, DUT sampled 1 time unit after the edge.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din, input logic clr);
    logic rd_ok, wr_ok;
    bus.Wr_enable   = wr;
    bus.Read_enable = rd;
    bus.data_in     = din;
    bus.clr_err     = clr;
    rd_ok = rd && (mcount != 0);
    wr_ok = wr && ((mcount != DEPTH) || rd);
    if (rd_ok) exp_q.push_back(mq.pop_front());
`ifdef FIFO_FWFT_EN
    if (rd_ok) check("fwft_head", bus.data_out, exp_q.pop_front());
`endif
    if (wr_ok) mq.push_back(din);
    if (wr && (mcount == DEPTH) && !rd) mov = 1'b1;
    else if (clr)                       mov = 1'b0;
    if (rd && (mcount == 0))            mun = 1'b1;
    else if (clr)                       mun = 1'b0;
    if (wr_ok && !rd_ok)      mcount++;
    else if (rd_ok && !wr_ok) mcount--;
    @(posedge clk);
    #1;
    check_flags();
    if (exp_q.size() != 0) check("read_data", bus.data_out, exp_q.pop_front());
  endtask

  initial begin
    reset           = 1'b0;
    bus.Wr_enable   = 1'b0;
    bus.Read_enable = 1'b0;
    bus.data_in     = '0;
    bus.clr_err     = 1'b0;
    #12;
    check_flags();
    check("reset_data_out", bus.data_out, '0);
    @(negedge clk);
    reset = 1'b1;

    // Fill completely then drain in order.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(32'h100 + i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0, 1'b0);

    // Threshold crossings: up to 12, down to 4.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, DW'(32'h300 + i), 1'b0);
    for (int i = 0; i < 8; i++)  step(1'b0, 1'b1, '0, 1'b0);

    // Fill, then overflow with 0xDEAD, then clear.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, DW'(32'h400 + i), 1'b0);
    step(1'b1, 1'b0, DW'(32'hDEAD), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Simultaneous read/write while full across pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'(32'h200 + i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0, 1'b0);

    // Read from empty with a simultaneous write of 0x55.
    step(1'b1, 1'b1, DW'(32'h55), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Asynchronous reset mid-burst at count 7.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'(32'h500 + i), 1'b0);
    bus.Wr_enable = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_count", DW'(bus.count), '0);
    check("async_empty", DW'(bus.empty), DW'(1));
    check("async_data_out", bus.data_out, '0);
    @(negedge clk);
    reset = 1'b1;

    step(1'b1, 1'b0, DW'(32'hA5), 1'b0);
`ifdef FIFO_FWFT_EN
    check("fwft_fall_through", bus.data_out, DW'(32'hA5));
`endif
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
